// File: rtl/mcf_drain_engine_pkg.sv
// Shared types and helpers for the multichannel FIFO drain engine.
// Holds the scan state encoding, the channel-index width helper and the
// burst counter width used by mcf_drain_engine and its sub-module.
package mcf_pkg;

   // Width of the per-visit burst counter (visits are limited to 1..255 words).
   localparam int burst_w = 8;

   // Scan states. SETTLE is the reset state and the entry point after any
   // RCS change or output handshake, so the FIFO's registered REMPTY/DO have
   // caught up before CHECK looks at them.
   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      CHECK  = 2'd1,
      OUT    = 2'd2,
      IDLE   = 2'd3
   } state_t;

   // Number of bits needed to index 'value' items (never less than 1).
   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/mcf_drain_engine_if.sv
// Bus bundle between the drain engine, the multichannel FIFO read port and
// the downstream valid/ready stream. The engine takes the master view; the
// FIFO plus the stream sink take the slave view.
interface mcf_drain_engine_if #(
   parameter int CW    = 4,
   parameter int Width = 32
);

   // FIFO read port
   logic [CW-1:0]    RCS;
   logic             REMPTY;
   logic             RD;
   logic [Width-1:0] DO;
   // FIFO timeout report
   logic             SKIP;
   logic [CW-1:0]    STT;
   // Output stream
   logic             M_VALID;
   logic             M_READY;
   logic [Width-1:0] M_DATA;
   logic [CW-1:0]    M_CH;
   logic             M_LAST;

   modport master (
      output RCS, RD, M_VALID, M_DATA, M_CH, M_LAST,
      input  REMPTY, DO, SKIP, STT, M_READY
   );

   modport slave (
      input  RCS, RD, M_VALID, M_DATA, M_CH, M_LAST,
      output REMPTY, DO, SKIP, STT, M_READY
   );

endinterface

// File: rtl/mcf_drain_engine_chan_pick.sv
// Next-channel selector for the drain engine. Purely combinational: if any
// channel is pending, the lowest-index one is chosen and a one-hot mask for
// clearing it is returned; otherwise the next channel is round-robin,
// wrapping from Channels-1 back to 0.
module mcf_chan_pick #(
   parameter int Channels = 16,
   parameter int CW       = 4
) (
   input  logic [CW-1:0]       cur_ch,
   input  logic [Channels-1:0] pending,
   output logic [CW-1:0]       next_ch,
   output logic [Channels-1:0] clr_mask
);

   // Priority pick over the pending vector, round-robin fallback.
   always_comb begin
      logic found;
      // NOTE: every output gets a default before any conditional assignment,
      // so no path leaves a value unassigned and no latch is inferred.
      found    = 1'b0;
      clr_mask = '0;
      next_ch  = (cur_ch == CW'(Channels - 1)) ? '0 : cur_ch + 1'b1;
      for (int i = 0; i < Channels; i++) begin
         if (pending[i] && !found) begin
            found       = 1'b1;
            next_ch     = CW'(i);
            clr_mask[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mcf_drain_engine.sv
// Multichannel FIFO drain engine.
// Scans FIFO channels round-robin, reads up to MaxBurst words per visit and
// presents each on a valid/ready stream tagged with its channel number.
// The FIFO's REMPTY and DO are registered against RCS and its read pointer,
// so every RCS change and every read is followed by a SETTLE cycle before
// the flags are trusted again; RD therefore fires at most once per 3 cycles.
// Optional feature macro: MCF_DRAIN_SKIP_PRIO_EN -- channels reported through
// SKIP/STT are remembered and visited ahead of round-robin order.
module mcf_drain_engine
   import mcf_pkg::*;
#(
   parameter int Channels = 16,
   parameter int Width    = 32,
   parameter int MaxBurst = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic EN,
   mcf_drain_engine_if.master bus
);

   localparam int CW = clogb2(Channels);
   localparam logic [burst_w-1:0] burst_max = burst_w'(MaxBurst);

   state_t               state;
   logic [burst_w-1:0]   burst;
   logic [CW-1:0]        rcs;
   logic                 m_valid;
   logic [Width-1:0]     m_data;
   logic [CW-1:0]        m_ch;
   logic                 m_last;

   logic                 at_limit;
   logic                 read_now;
   logic                 advance;
   logic [CW-1:0]        next_ch;
   logic [Channels-1:0]  clr_mask;
   logic [Channels-1:0]  pick_pending;

   // A visit ends when the burst budget is spent or the channel runs dry.
   assign at_limit = (burst == burst_max);
   assign read_now = (state == CHECK) && EN && !bus.REMPTY && !at_limit;
   assign advance  = (state == CHECK) && EN && (bus.REMPTY || at_limit);

   assign bus.RD      = read_now;
   assign bus.RCS     = rcs;
   assign bus.M_VALID = m_valid;
   assign bus.M_DATA  = m_data;
   assign bus.M_CH    = m_ch;
   assign bus.M_LAST  = m_last;

   mcf_chan_pick #(
      .Channels (Channels),
      .CW       (CW)
   ) u_pick (
      .cur_ch   (rcs),
      .pending  (pick_pending),
      .next_ch  (next_ch),
      .clr_mask (clr_mask)
   );

`ifdef MCF_DRAIN_SKIP_PRIO_EN
   logic [Channels-1:0] pending;
   logic [Channels-1:0] set_mask;
   logic [Channels-1:0] clear_mask;

   // Decode the timeout report into a one-hot set request.
   always_comb begin
      set_mask = '0;
      if (bus.SKIP) set_mask = Channels'(1) << bus.STT;
   end

   assign clear_mask = advance ? clr_mask : '0;

   // Pending timeouts; OR-ing the set after the clear lets a same-cycle set win.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clear_mask) | set_mask;
      end
   end

   assign pick_pending = pending;
`else
   assign pick_pending = '0;
`endif

   // Scan FSM with registered FIFO select and output stream registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         // NOTE: the output data register is reset as well as the control
         // state, so M_DATA reads 0 after reset rather than a stale word.
         state   <= SETTLE;
         burst   <= '0;
         rcs     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_ch    <= '0;
         m_last  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads
         // the pre-edge values of burst/rcs regardless of statement order.
         case (state)
            SETTLE: begin
               state <= CHECK;
            end

            CHECK: begin
               if (!EN) begin
                  state <= IDLE;
               end else if (bus.REMPTY || at_limit) begin
                  rcs   <= next_ch;
                  burst <= '0;
                  state <= SETTLE;
               end else begin
                  m_data  <= bus.DO;
                  m_ch    <= rcs;
                  m_last  <= ((burst + 1'b1) == burst_max);
                  m_valid <= 1'b1;
                  burst   <= burst + 1'b1;
                  state   <= OUT;
               end
            end

            OUT: begin
               if (bus.M_READY) begin
                  m_valid <= 1'b0;
                  state   <= SETTLE;
               end
            end

            IDLE: begin
               if (EN) state <= SETTLE;
            end

            default: begin
               state <= SETTLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcf_drain_engine.sv
// Directed testbench for mcf_drain_engine. A small behavioural FIFO model
// provides registered REMPTY/DO; a sink records accepted words; a monitor
// checks RD spacing and that RD never hits an empty channel.
module tb_mcf_drain_engine;
   import mcf_pkg::*;

   localparam int Channels = 16;
   localparam int Width    = 32;
   localparam int MaxBurst = 4;
   localparam int CW       = clogb2(Channels);

   typedef logic [Width-1:0] word_q_t [$];

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   logic EN    = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   mcf_drain_engine_if #(.CW(CW), .Width(Width)) bus ();

   mcf_drain_engine #(
      .Channels (Channels),
      .Width    (Width),
      .MaxBurst (MaxBurst)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (EN),
      .bus   (bus)
   );

   // ---------------- FIFO model ----------------
   word_q_t fifo_q [Channels];

   initial begin
      bus.REMPTY = 1'b1;
      bus.DO     = '0;
   end

   // Registered flags: pop on RD, then present emptiness/head of the channel
   // that RCS selected before this edge.
   always @(posedge CLK) begin
      int ch;
      ch = int'(bus.RCS);
      if (bus.RD === 1'b1 && fifo_q[ch].size() > 0) void'(fifo_q[ch].pop_front());
      bus.REMPTY <= (fifo_q[ch].size() == 0);
      bus.DO     <= (fifo_q[ch].size() > 0) ? fifo_q[ch][0] : '0;
   end

   // ---------------- monitors ----------------
   int cyc = 0;
   int rd_count = 0;
   int last_rd_cyc = -100;
   logic [Width-1:0] got_data [$];
   logic [CW-1:0]    got_ch [$];
   logic             got_last [$];

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (RESET === 1'b1 && bus.RD === 1'b1) begin
         rd_count++;
         checks++;
         if (cyc - last_rd_cyc < 3) begin
            errors++;
            $display("FAIL rd_gap: RD %0d cycles after previous, need >= 3", cyc - last_rd_cyc);
         end
         checks++;
         if (fifo_q[int'(bus.RCS)].size() == 0) begin
            errors++;
            $display("FAIL rd_underflow: RD on empty channel %0d, need non-empty", bus.RCS);
         end
         last_rd_cyc = cyc;
      end
      if (bus.M_VALID === 1'b1 && bus.M_READY === 1'b1) begin
         got_data.push_back(bus.M_DATA);
         got_ch.push_back(bus.M_CH);
         got_last.push_back(bus.M_LAST);
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Assert reset and empty the FIFO model and the capture queues.
   task automatic hold_reset();
      RESET       = 1'b0;
      EN          = 1'b0;
      bus.M_READY = 1'b0;
      bus.SKIP    = 1'b0;
      bus.STT     = '0;
      for (int i = 0; i < Channels; i++) fifo_q[i].delete();
      got_data.delete();
      got_ch.delete();
      got_last.delete();
      step(1);
   endtask

   // Let the FIFO model flags track RCS=0, then release away from the edge.
   task automatic release_reset();
      step(2);
      RESET = 1'b1;
   endtask

   task automatic wait_words(input int n, input int budget);
      int k;
      k = 0;
      while (got_data.size() < n && k < budget) begin
         step(1);
         k++;
      end
      checks++;
      if (got_data.size() < n) begin
         errors++;
         $display("FAIL wait_words: got %0d words, need %0d", got_data.size(), n);
      end
   endtask

   task automatic wait_valid(input int budget);
      int k;
      k = 0;
      while (bus.M_VALID !== 1'b1 && k < budget) begin
         step(1);
         k++;
      end
      checks++;
      if (bus.M_VALID !== 1'b1) begin
         errors++;
         $display("FAIL wait_valid: M_VALID=%b, need 1", bus.M_VALID);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      hold_reset();
      step(2);
      checks += 6;
      if (bus.RCS !== '0)     begin errors++; $display("FAIL reset_rcs: got %0h need 0", bus.RCS); end
      if (bus.RD !== 1'b0)    begin errors++; $display("FAIL reset_rd: got %b need 0", bus.RD); end
      if (bus.M_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", bus.M_VALID); end
      if (bus.M_DATA !== '0)  begin errors++; $display("FAIL reset_data: got %h need 0", bus.M_DATA); end
      if (bus.M_CH !== '0)    begin errors++; $display("FAIL reset_ch: got %0h need 0", bus.M_CH); end
      if (bus.M_LAST !== 1'b0) begin errors++; $display("FAIL reset_last: got %b need 0", bus.M_LAST); end
   endtask

   task automatic test_single_channel();
      logic [Width-1:0] exp_d [2];
      exp_d[0] = 32'hA1A1_0001;
      exp_d[1] = 32'hA1A1_0002;
      hold_reset();
      fifo_q[3].push_back(exp_d[0]);
      fifo_q[3].push_back(exp_d[1]);
      bus.M_READY = 1'b1;
      EN          = 1'b1;
      release_reset();
      wait_words(2, 100);
      for (int i = 0; i < 2 && i < got_data.size(); i++) begin
         checks += 3;
         if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL single_data[%0d]: got %h need %h", i, got_data[i], exp_d[i]); end
         if (got_ch[i] !== CW'(3))     begin errors++; $display("FAIL single_ch[%0d]: got %0d need 3", i, got_ch[i]); end
         if (got_last[i] !== 1'b0)     begin errors++; $display("FAIL single_last[%0d]: got %b need 0", i, got_last[i]); end
      end
      step(80);
      checks += 2;
      if (got_data.size() != 2)   begin errors++; $display("FAIL single_extra: got %0d words need 2", got_data.size()); end
      if (fifo_q[3].size() != 0)  begin errors++; $display("FAIL single_drain: ch3 holds %0d need 0", fifo_q[3].size()); end
   endtask

   task automatic test_burst();
      logic [Width-1:0] exp_d [7];
      logic [CW-1:0]    exp_c [7];
      logic             exp_l [7];
      hold_reset();
      for (int i = 0; i < 6; i++) fifo_q[0].push_back(32'hB000_0000 + Width'(i));
      fifo_q[1].push_back(32'hC000_0001);
      exp_d = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
                32'hC000_0001, 32'hB000_0004, 32'hB000_0005};
      exp_c = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      bus.M_READY = 1'b1;
      EN          = 1'b1;
      release_reset();
      wait_words(7, 300);
      for (int i = 0; i < 7 && i < got_data.size(); i++) begin
         checks += 3;
         if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL burst_data[%0d]: got %h need %h", i, got_data[i], exp_d[i]); end
         if (got_ch[i] !== exp_c[i])   begin errors++; $display("FAIL burst_ch[%0d]: got %0d need %0d", i, got_ch[i], exp_c[i]); end
         if (got_last[i] !== exp_l[i]) begin errors++; $display("FAIL burst_last[%0d]: got %b need %b", i, got_last[i], exp_l[i]); end
      end
   endtask

   task automatic test_stall();
      int rd_base;
      hold_reset();
      fifo_q[5].push_back(32'hD000_0000);
      fifo_q[5].push_back(32'hD000_0001);
      bus.M_READY = 1'b0;
      EN          = 1'b1;
      release_reset();
      wait_valid(100);
      rd_base = rd_count;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         checks += 3;
         if (bus.M_VALID !== 1'b1)         begin errors++; $display("FAIL stall_valid[%0d]: got %b need 1", i, bus.M_VALID); end
         if (bus.M_DATA !== 32'hD000_0000) begin errors++; $display("FAIL stall_data[%0d]: got %h need d0000000", i, bus.M_DATA); end
         if (bus.M_CH !== CW'(5))          begin errors++; $display("FAIL stall_ch[%0d]: got %0d need 5", i, bus.M_CH); end
      end
      checks++;
      if (rd_count != rd_base) begin errors++; $display("FAIL stall_rd: %0d RDs during stall need 0", rd_count - rd_base); end
      step(1);
      bus.M_READY = 1'b1;
      wait_words(2, 100);
      step(10);
      checks += 3;
      if (got_data.size() > 0 && got_data[0] !== 32'hD000_0000) begin errors++; $display("FAIL stall_w0: got %h need d0000000", got_data[0]); end
      if (got_data.size() > 1 && got_data[1] !== 32'hD000_0001) begin errors++; $display("FAIL stall_w1: got %h need d0000001", got_data[1]); end
      if (rd_count != rd_base + 1) begin errors++; $display("FAIL stall_rd_after: %0d RDs after release need 1", rd_count - rd_base); end
   endtask

   task automatic test_reset_in_out();
      hold_reset();
      fifo_q[2].push_back(32'hF000_0000);
      bus.M_READY = 1'b0;
      EN          = 1'b1;
      release_reset();
      wait_valid(100);
      @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      checks += 7;
      if (bus.RCS !== '0)       begin errors++; $display("FAIL async_rcs: got %0h need 0", bus.RCS); end
      if (bus.RD !== 1'b0)      begin errors++; $display("FAIL async_rd: got %b need 0", bus.RD); end
      if (bus.M_VALID !== 1'b0) begin errors++; $display("FAIL async_valid: got %b need 0", bus.M_VALID); end
      if (bus.M_DATA !== '0)    begin errors++; $display("FAIL async_data: got %h need 0", bus.M_DATA); end
      if (bus.M_CH !== '0)      begin errors++; $display("FAIL async_ch: got %0h need 0", bus.M_CH); end
      if (bus.M_LAST !== 1'b0)  begin errors++; $display("FAIL async_last: got %b need 0", bus.M_LAST); end
      if (fifo_q[2].size() != 0) begin errors++; $display("FAIL async_consumed: ch2 holds %0d need 0", fifo_q[2].size()); end
      got_data.delete();
      got_ch.delete();
      got_last.delete();
      fifo_q[1].push_back(32'hF000_0001);
      bus.M_READY = 1'b1;
      release_reset();
      step(1);
      checks++;
      if (bus.RCS !== '0) begin errors++; $display("FAIL resume_rcs: got %0h need 0", bus.RCS); end
      wait_words(1, 100);
      step(40);
      checks += 3;
      if (got_data.size() != 1) begin errors++; $display("FAIL resume_count: got %0d words need 1", got_data.size()); end
      if (got_data.size() > 0 && got_data[0] !== 32'hF000_0001) begin errors++; $display("FAIL resume_data: got %h need f0000001", got_data[0]); end
      if (got_ch.size() > 0 && got_ch[0] !== CW'(1)) begin errors++; $display("FAIL resume_ch: got %0d need 1", got_ch[0]); end
   endtask

   task automatic test_enable();
      int rd_base;
      hold_reset();
      for (int c = 0; c < Channels; c++) begin
         fifo_q[c].push_back(32'hE000_0000 | (Width'(c) << 8));
         fifo_q[c].push_back(32'hE000_0001 | (Width'(c) << 8));
      end
      bus.M_READY = 1'b1;
      EN          = 1'b1;
      release_reset();
      wait_words(1, 100);
      EN = 1'b0;
      step(2);
      rd_base = rd_count;
      step(20);
      checks += 3;
      if (rd_count != rd_base)  begin errors++; $display("FAIL en_rd: %0d RDs with EN=0 need 0", rd_count - rd_base); end
      if (bus.RCS !== '0)       begin errors++; $display("FAIL en_rcs: got %0h need 0", bus.RCS); end
      if (got_data.size() != 1) begin errors++; $display("FAIL en_count: got %0d words need 1", got_data.size()); end
      EN = 1'b1;
      wait_words(2, 100);
      checks += 3;
      if (got_data[0] !== 32'hE000_0000) begin errors++; $display("FAIL en_w0: got %h need e0000000", got_data[0]); end
      if (got_data.size() > 1 && got_data[1] !== 32'hE000_0001) begin errors++; $display("FAIL en_w1: got %h need e0000001", got_data[1]); end
      if (got_ch.size() > 1 && got_ch[1] !== CW'(0)) begin errors++; $display("FAIL en_ch1: got %0d need 0", got_ch[1]); end
   endtask

   task automatic test_skip();
      logic [Width-1:0] exp_d [3];
      logic [CW-1:0]    exp_c [3];
`ifdef MCF_DRAIN_SKIP_PRIO_EN
      exp_d = '{32'h6000_0002, 32'h6000_0009, 32'h6000_0005};
      exp_c = '{4'd2, 4'd9, 4'd5};
`else
      exp_d = '{32'h6000_0002, 32'h6000_0005, 32'h6000_0009};
      exp_c = '{4'd2, 4'd5, 4'd9};
`endif
      hold_reset();
      fifo_q[2].push_back(32'h6000_0002);
      fifo_q[5].push_back(32'h6000_0005);
      fifo_q[9].push_back(32'h6000_0009);
      bus.M_READY = 1'b0;
      EN          = 1'b1;
      release_reset();
      wait_valid(100);
      checks++;
      if (bus.RCS !== CW'(2)) begin errors++; $display("FAIL skip_start_rcs: got %0d need 2", bus.RCS); end
      bus.SKIP = 1'b1;
      bus.STT  = CW'(9);
      step(1);
      bus.SKIP = 1'b0;
      bus.STT  = '0;
      bus.M_READY = 1'b1;
      wait_words(3, 200);
      for (int i = 0; i < 3 && i < got_data.size(); i++) begin
         checks += 2;
         if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL skip_data[%0d]: got %h need %h", i, got_data[i], exp_d[i]); end
         if (got_ch[i] !== exp_c[i])   begin errors++; $display("FAIL skip_ch[%0d]: got %0d need %0d", i, got_ch[i], exp_c[i]); end
      end
   endtask

   // Global time bound so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.M_READY = 1'b0;
      bus.SKIP    = 1'b0;
      bus.STT     = '0;
      test_reset();
      test_single_channel();
      test_burst();
      test_stall();
      test_reset_in_out();
      test_enable();
      test_skip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
